clk_monitor: RTL

//   Receive-side counterpart of the bench clock source: samples a monitored clock-like

---
 rtl/clk_mon_pkg.sv | 17 +
 rtl/clk_mon_sync.sv | 38 +++
 rtl/clk_monitor.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg
//   Shared definitions for the clock activity monitor: FSM state encoding and
//   the width of the completed-measurement counter.
package clk_mon_pkg;

    // Monitor FSM states. Encodings are fixed so they can be probed externally.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSeek    = 2'd1,
        StMeasure = 2'd2,
        StStall   = 2'd3
    } mon_state_e;

    // Width of meas_count; wraps from all-ones back to zero.
    localparam int unsigned MeasCntW = 8;

endpackage

// File: rtl/clk_mon_sync.sv
// clk_mon_sync
//   Brings the asynchronous monitored signal into the clk domain with a
//   two-flop synchronizer and detects its rising edge.
// Ports
//   clk     in   system clock, rising edge
//   reset   in   synchronous active-high reset, clears all flops
//   mon_in  in   monitored signal, asynchronous to clk
//   s       out  synchronized copy of mon_in
//   rise    out  one-cycle pulse on the first cycle s is high
module clk_mon_sync (
    input  logic clk,
    input  logic reset,
    input  logic mon_in,
    output logic s,
    output logic rise
);

    logic meta_q;
    logic s_q;
    logic s_dly_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b0;
            s_q     <= 1'b0;
            s_dly_q <= 1'b0;
        end else begin
            meta_q  <= mon_in;
            s_q     <= meta_q;
            s_dly_q <= s_q;
        end
    end

    assign s    = s_q;
    // Combinational so the FSM consumes the edge on the following clk edge.
    assign rise = s_q & ~s_dly_q;

endmodule

// File: rtl/clk_monitor.sv
// clk_monitor
//   Samples a clock-like signal with the system clock, measures its period
//   and high time in clk cycles, and flags a stalled or gated source.
// Parameters
//   CNT_W    width of period/high-time counters and outputs
//   TIMEOUT  clk cycles without a rising edge before stalled asserts
//            (2 .. 2**CNT_W-1, so the counters can never overflow)
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous active-high reset
//   mon_en      in   monitor enable; low forces the idle state
//   mon_in      in   monitored signal, asynchronous to clk
//   period      out  last rising-to-rising interval in clk cycles
//   high_time   out  cycles the synced input was high within that interval
//   meas_valid  out  one-cycle pulse when period/high_time update
//   stalled     out  no rising edge seen for TIMEOUT cycles
//   meas_count  out  completed measurements, wraps
module clk_monitor
    import clk_mon_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mon_en,
    input  logic                mon_in,
    output logic [CNT_W-1:0]    period,
    output logic [CNT_W-1:0]    high_time,
    output logic                meas_valid,
    output logic                stalled,
    output logic [MeasCntW-1:0] meas_count
);

    localparam logic [CNT_W-1:0]    TimeoutVal = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]    CntOne     = CNT_W'(1);
    localparam logic [MeasCntW-1:0] MeasOne    = MeasCntW'(1);

    logic s;
    logic rise;

    clk_mon_sync u_sync (
        .clk    (clk),
        .reset  (reset),
        .mon_in (mon_in),
        .s      (s),
        .rise   (rise)
    );

    mon_state_e            state_q,     state_d;
    logic [CNT_W-1:0]      per_cnt_q,   per_cnt_d;
    logic [CNT_W-1:0]      hi_cnt_q,    hi_cnt_d;
    logic [CNT_W-1:0]      period_q,    period_d;
    logic [CNT_W-1:0]      high_time_q, high_time_d;
    logic                  valid_q,     valid_d;
    logic                  stalled_q,   stalled_d;
    logic [MeasCntW-1:0]   count_q,     count_d;
    logic                  hit_timeout;

    always_comb begin
        state_d     = state_q;
        per_cnt_d   = per_cnt_q;
        hi_cnt_d    = hi_cnt_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        valid_d     = 1'b0;
        stalled_d   = stalled_q;
        count_d     = count_q;
        hit_timeout = (per_cnt_q == TimeoutVal);

        if (!mon_en) begin
            // Disable abandons the interval but keeps the last results visible.
            state_d   = StIdle;
            stalled_d = 1'b0;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // The entry cycle counts, so the stall fires TIMEOUT cycles
                    // after entering the seek state.
                    state_d   = StSeek;
                    per_cnt_d = CntOne;
                    hi_cnt_d  = '0;
                end
                StSeek: begin
                    if (rise) begin
                        // First edge only opens an interval; nothing to report yet.
                        state_d   = StMeasure;
                        per_cnt_d = CntOne;
                        hi_cnt_d  = CntOne;
                    end else if (hit_timeout) begin
                        state_d   = StStall;
                        stalled_d = 1'b1;
                    end else begin
                        per_cnt_d = per_cnt_q + CntOne;
                    end
                end
                StMeasure: begin
                    // A rise on the timeout cycle still closes a valid interval.
                    if (rise) begin
                        period_d    = per_cnt_q;
                        high_time_d = hi_cnt_q;
                        valid_d     = 1'b1;
                        count_d     = count_q + MeasOne;
                        per_cnt_d   = CntOne;
                        hi_cnt_d    = CntOne;
                    end else if (hit_timeout) begin
                        state_d   = StStall;
                        stalled_d = 1'b1;
                    end else begin
                        per_cnt_d = per_cnt_q + CntOne;
                        if (s) begin
                            hi_cnt_d = hi_cnt_q + CntOne;
                        end
                    end
                end
                StStall: begin
                    // The interval spanning the stall is meaningless; restart clean.
                    if (rise) begin
                        state_d   = StMeasure;
                        stalled_d = 1'b0;
                        per_cnt_d = CntOne;
                        hi_cnt_d  = CntOne;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            per_cnt_q   <= '0;
            hi_cnt_q    <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            stalled_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            per_cnt_q   <= per_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            valid_q     <= valid_d;
            stalled_q   <= stalled_d;
            count_q     <= count_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = valid_q;
    assign stalled    = stalled_q;
    assign meas_count = count_q;

endmodule
